// File: rtl/ahb_mtx_in_stg.sv
// AHB bus-matrix input stage: forwards or holds one address-phase transfer per
// slave port and returns data-phase ready/response to the master.
module ahb_mtx_in_stg #(
  parameter int ADDR_W       = 32,
  parameter bit HOLD_ON_IDLE = 1'b0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              sel_in,
  output logic [ADDR_W-1:0] addr_in,
  output logic [1:0]        trans_in,
  output logic              write_in,
  output logic [2:0]        size_in,
  output logic [2:0]        burst_in,
  output logic [3:0]        prot_in,
  output logic              held_tran,
  input  logic              active_in,
  input  logic              ready_in,
  input  logic              readyout_in,
  input  logic [1:0]        resp_in
);

  // Handshake: a transfer presented on sel_in/trans_in moves to the output stage
  // in the cycle active_in & ready_in are high; a held transfer stays presented
  // (sel_in=1) until that cycle, and HREADYOUTS=0 stalls the master meanwhile.

  logic              pend_q, pend_d;
  logic              dphase_q, dphase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        trans_q, trans_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [2:0]        burst_q, burst_d;
  logic [3:0]        prot_q, prot_d;

  logic new_tran, load_req, accept, issue, err_cancel, load;

  assign new_tran   = HSELS & HTRANSS[1] & HREADYS;
  assign load_req   = new_tran | (HOLD_ON_IDLE & HSELS & HREADYS);
  assign accept     = sel_in & trans_in[1] & active_in & ready_in;
  assign issue      = pend_q & active_in & ready_in;
  // First ERROR cycle: the master will re-drive, so the held transfer is dropped.
  assign err_cancel = dphase_q & (resp_in == 2'b01) & ~readyout_in & pend_q;
  assign load       = load_req & ~pend_q & ~accept;

  // Decoder-side mux: holding register while pending, else master pass-through.
  always_comb begin
    if (pend_q) begin
      sel_in   = 1'b1;
      addr_in  = addr_q;
      trans_in = trans_q;
      write_in = write_q;
      size_in  = size_q;
      burst_in = burst_q;
      prot_in  = prot_q;
    end else begin
      sel_in   = HSELS;
      addr_in  = HADDRS;
      trans_in = HTRANSS;
      write_in = HWRITES;
      size_in  = HSIZES;
      burst_in = HBURSTS;
      prot_in  = HPROTS;
    end
  end

  always_comb begin
    pend_d   = pend_q;
    dphase_d = dphase_q;
    addr_d   = addr_q;
    trans_d  = trans_q;
    write_d  = write_q;
    size_d   = size_q;
    burst_d  = burst_q;
    prot_d   = prot_q;
    if (load) begin
      pend_d  = 1'b1;
      addr_d  = HADDRS;
      trans_d = HTRANSS;
      write_d = HWRITES;
      size_d  = HSIZES;
      burst_d = HBURSTS;
      prot_d  = HPROTS;
    end else if (err_cancel || issue) begin
      pend_d = 1'b0;
    end
    if (accept) begin
      dphase_d = 1'b1;
    end else if (readyout_in) begin
      dphase_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q   <= 1'b0;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      trans_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      burst_q  <= '0;
      prot_q   <= '0;
    end else begin
      pend_q   <= pend_d;
      dphase_q <= dphase_d;
      addr_q   <= addr_d;
      trans_q  <= trans_d;
      write_q  <= write_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      prot_q   <= prot_d;
    end
  end

  always_comb begin
    if (dphase_q)    HREADYOUTS = readyout_in;
    else if (pend_q) HREADYOUTS = 1'b0;
    else             HREADYOUTS = 1'b1;
    HRESPS    = dphase_q ? resp_in : 2'b00;
    held_tran = pend_q;
  end

endmodule

// File: tb/tb_ahb_mtx_in_stg.sv
// Bench for ahb_mtx_in_stg: directed scenarios followed by random traffic,
// all checked against a transaction-level model (depth-1 hold queue).
module tb_ahb_mtx_in_stg;

  localparam int ADDR_W       = 32;
  localparam bit HOLD_ON_IDLE = 1'b0;

  logic              clk = 1'b0;
  logic              HRESET;
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;
  logic              sel_in;
  logic [ADDR_W-1:0] addr_in;
  logic [1:0]        trans_in;
  logic              write_in;
  logic [2:0]        size_in;
  logic [2:0]        burst_in;
  logic [3:0]        prot_in;
  logic              held_tran;
  logic              active_in;
  logic              ready_in;
  logic              readyout_in;
  logic [1:0]        resp_in;

  always #5 clk = ~clk;

  ahb_mtx_in_stg #(.ADDR_W(ADDR_W), .HOLD_ON_IDLE(HOLD_ON_IDLE)) dut (
    .HCLK(clk), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_in(sel_in), .addr_in(addr_in), .trans_in(trans_in), .write_in(write_in),
    .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in),
    .held_tran(held_tran), .active_in(active_in), .ready_in(ready_in),
    .readyout_in(readyout_in), .resp_in(resp_in)
  );

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              wr;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
  } xfer_t;

  // Model state: queue of waiting transfers (never more than one), data-phase flag.
  xfer_t held_q[$];
  bit    m_dphase = 1'b0;
  bit    m_known  = 1'b0;
  int    n_pass   = 0;
  int    n_total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic xfer_t master_xfer();
    xfer_t x;
    x.sel = HSELS; x.addr = HADDRS; x.trans = HTRANSS; x.wr = HWRITES;
    x.size = HSIZES; x.burst = HBURSTS; x.prot = HPROTS;
    return x;
  endfunction

  // Check combinational outputs against the model, then advance model and clock.
  task automatic tick();
    xfer_t pres;
    bit    pend, acc;
    #2;
    pend = (held_q.size() != 0);
    if (pend) begin
      pres = held_q[0];
      pres.sel = 1'b1;
    end else begin
      pres = master_xfer();
    end
    if (m_known) begin
      chk("sel_in", sel_in, pres.sel);
      chk("addr_in", addr_in, pres.addr);
      chk("trans_in", trans_in, pres.trans);
      chk("write_in", write_in, pres.wr);
      chk("size_in", size_in, pres.size);
      chk("burst_in", burst_in, pres.burst);
      chk("prot_in", prot_in, pres.prot);
      chk("held_tran", held_tran, pend);
      chk("HREADYOUTS", HREADYOUTS, m_dphase ? readyout_in : !pend);
      chk("HRESPS", HRESPS, m_dphase ? resp_in : 2'b00);
    end
    if (HRESET) begin
      held_q.delete();
      m_dphase = 1'b0;
      m_known  = 1'b1;
    end else if (m_known) begin
      acc = pres.sel && pres.trans[1] && active_in && ready_in;
      if (pend) begin
        if (m_dphase && resp_in == 2'b01 && !readyout_in) held_q.delete();
        else if (active_in && ready_in) void'(held_q.pop_front());
      end else if (HSELS && HREADYS && (HTRANSS[1] || HOLD_ON_IDLE) && !acc) begin
        held_q.push_back(master_xfer());
      end
      if (acc) m_dphase = 1'b1;
      else if (readyout_in) m_dphase = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                       input logic hrdy, input logic act, input logic rdy);
    HSELS = sel; HTRANSS = tr; HADDRS = addr; HREADYS = hrdy;
    active_in = act; ready_in = rdy;
  endtask

  initial begin
    HRESET = 1'b1; HWRITES = 1'b1; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'd3;
    readyout_in = 1'b1; resp_in = 2'b00;
    drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tick(); tick();
    HRESET = 1'b0;
    #2;
    chk("reset_hreadyout", HREADYOUTS, 1'b1);
    chk("reset_hresp", HRESPS, 2'b00);
    chk("reset_held", held_tran, 1'b0);
    tick();

    // Direct NONSEQ accepted same cycle.
    drive(1'b1, 2'b10, 32'h0000_0100, 1'b1, 1'b1, 1'b1);
    #2;
    chk("direct_addr", addr_in, 32'h0000_0100);
    chk("direct_held", held_tran, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    readyout_in = 1'b0;
    tick();
    readyout_in = 1'b1;
    tick();

    // Blocked NONSEQ held for 3 cycles, then accepted.
    drive(1'b1, 2'b10, 32'h2000_0000, 1'b1, 1'b0, 1'b1);
    tick();
    HREADYS = 1'b0;
    #2;
    chk("hold_held", held_tran, 1'b1);
    chk("hold_hreadyout", HREADYOUTS, 1'b0);
    chk("hold_addr", addr_in, 32'h2000_0000);
    tick(); tick(); tick();
    active_in = 1'b1;
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    readyout_in = 1'b0;
    #2;
    chk("issued_held", held_tran, 1'b0);
    chk("issued_dphase_rdy", HREADYOUTS, 1'b0);
    tick();
    readyout_in = 1'b1;
    tick();

    // Held transfer dropped on the first ERROR cycle.
    drive(1'b1, 2'b10, 32'h0000_0400, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 2'b10, 32'h0000_0800, 1'b1, 1'b0, 1'b1);
    readyout_in = 1'b0;
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    resp_in = 2'b01;
    #2;
    chk("err1_held", held_tran, 1'b1);
    chk("err1_resp", HRESPS, 2'b01);
    tick();
    readyout_in = 1'b1;
    #2;
    chk("err2_held", held_tran, 1'b0);
    chk("err2_resp", HRESPS, 2'b01);
    chk("err2_hreadyout", HREADYOUTS, 1'b1);
    tick();
    resp_in = 2'b00;
    tick();

    // Back-to-back NONSEQ + 3 SEQ beats, readyout_in=1 throughout.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h0000_1000 + 32'(4 * i), 1'b1, 1'b1, 1'b1);
      #2;
      chk("b2b_held", held_tran, 1'b0);
      chk("b2b_hreadyout", HREADYOUTS, 1'b1);
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();

    // Reset while both pending and in data phase.
    drive(1'b1, 2'b10, 32'h0000_2000, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 2'b10, 32'h0000_3000, 1'b1, 1'b0, 1'b1);
    readyout_in = 1'b0;
    tick();
    HRESET = 1'b1;
    HREADYS = 1'b0;
    tick();
    HRESET = 1'b0;
    HSELS = 1'b1;
    HTRANSS = 2'b00;
    #2;
    chk("rst2_hreadyout", HREADYOUTS, 1'b1);
    chk("rst2_hresp", HRESPS, 2'b00);
    chk("rst2_held", held_tran, 1'b0);
    chk("rst2_sel", sel_in, 1'b1);
    readyout_in = 1'b1;
    tick();

    // IDLE with active_in=0 passes through without holding.
    drive(1'b1, 2'b00, 32'h0000_5000, 1'b1, 1'b0, 1'b1);
    #2;
    chk("idle_trans", trans_in, 2'b00);
    tick();
    #2;
    chk("idle_held", held_tran, 1'b0);
    chk("idle_hreadyout", HREADYOUTS, 1'b1);
    tick();

    // Random traffic; bus HREADY follows this port's expected HREADYOUT.
    for (int i = 0; i < 400; i++) begin
      HSELS       = ($urandom_range(0, 3) != 0);
      HTRANSS     = 2'($urandom_range(0, 3));
      HADDRS      = $urandom;
      HWRITES     = 1'($urandom_range(0, 1));
      HSIZES      = 3'($urandom_range(0, 7));
      HBURSTS     = 3'($urandom_range(0, 7));
      HPROTS      = 4'($urandom_range(0, 15));
      active_in   = ($urandom_range(0, 2) != 0);
      ready_in    = ($urandom_range(0, 3) != 0);
      readyout_in = ($urandom_range(0, 3) != 0);
      resp_in     = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      HREADYS     = m_dphase ? readyout_in : (held_q.size() == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
